// File: rtl/video_vram_arbiter.sv
// video_vram_arbiter
//
// Owns the PPU VRAM bus and shares it between host PPUDATA accesses and the
// render fetcher. It also holds the PPUADDR registers (t, v and the two-write
// toggle w), the PPUDATA auto-increment and the PPUDATA read buffer.
//
// Ports
//   I_clock, I_reset            system clock, synchronous active-high reset
//   I_tick                      one-clock PPU dot enable; arbitration only advances on it
//   I_rendering                 1: render wins arbitration, 0: host wins
//   I_incr32                    PPUCTRL[2]; PPUDATA step is P_incr_big instead of 1
//   I_addr_wr, I_data_wr,
//   I_data_rd, I_stat_rd,
//   I_host_data                 host register strobes and write data
//   O_read_buffer               PPUDATA read buffer (value of the last completed read)
//   O_host_busy                 host op pending or in flight
//   O_overrun                   sticky: a host strobe was dropped
//   I_render_req, I_render_addr render fetch request (held until ack) and address
//   O_render_ack, O_render_data one-clock ack with fetched data
//   O_vid_addr, O_vid_wren,
//   O_vid_data, I_vid_data      external VRAM port
//
// Build option
//   VIDEO_VRAM_MIRROR_EN        when defined, addresses 0x3000-0x3EFF are driven on
//                               O_vid_addr with bit 12 cleared (0x2000-0x2EFF mirror).
//                               The internal v register is never altered by this.
//
// FSM
//   state  | meaning
//   IDLE   | bus parked (O_vid_addr holds); waiting for a tick with a request
//   ACCESS | one access owns the bus; it completes on the next tick

module video_vram_arbiter #(
    parameter int P_addr_width = 14,
    parameter int P_data_width = 8,
    parameter int P_incr_big   = 32
) (
    input  logic                    I_clock,
    input  logic                    I_reset,
    input  logic                    I_tick,
    input  logic                    I_rendering,
    input  logic                    I_incr32,
    input  logic                    I_addr_wr,
    input  logic                    I_data_wr,
    input  logic                    I_data_rd,
    input  logic                    I_stat_rd,
    input  logic [P_data_width-1:0] I_host_data,
    output logic [P_data_width-1:0] O_read_buffer,
    output logic                    O_host_busy,
    output logic                    O_overrun,
    input  logic                    I_render_req,
    input  logic [P_addr_width-1:0] I_render_addr,
    output logic                    O_render_ack,
    output logic [P_data_width-1:0] O_render_data,
    output logic [P_addr_width-1:0] O_vid_addr,
    output logic                    O_vid_wren,
    input  logic [P_data_width-1:0] I_vid_data,
    output logic [P_data_width-1:0] O_vid_data
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [P_addr_width-1:0] L_incr_one = P_addr_width'(1);
    localparam logic [P_addr_width-1:0] L_incr_big = P_addr_width'(P_incr_big);

    state_t                  state_q, state_d;
    logic [P_addr_width-1:0] v_q, v_d;
    logic [P_addr_width-1:0] t_q, t_d;
    logic                    w_q, w_d;
    logic                    pend_valid_q, pend_valid_d;
    logic                    pend_wr_q, pend_wr_d;
    logic [P_addr_width-1:0] pend_addr_q, pend_addr_d;
    logic [P_data_width-1:0] pend_data_q, pend_data_d;
    logic                    owner_render_q, owner_render_d;
    logic [P_addr_width-1:0] vid_addr_q, vid_addr_d;
    logic                    vid_wren_q, vid_wren_d;
    logic [P_data_width-1:0] vid_data_q, vid_data_d;
    logic                    render_ack_q, render_ack_d;
    logic [P_data_width-1:0] render_data_q, render_data_d;
    logic [P_data_width-1:0] read_buffer_q, read_buffer_d;
    logic                    overrun_q, overrun_d;

    logic                    render_req_eff;
    logic                    host_req;
    logic                    grant_render;
    logic                    grant_host;
    logic                    complete;
    logic                    data_strobe;
    logic                    host_accept;
    logic [P_addr_width-1:0] incr;

    // Address actually driven on the VRAM bus for a given logical address.
    function automatic logic [P_addr_width-1:0] vid_map(input logic [P_addr_width-1:0] a);
        logic [P_addr_width-1:0] m;
        m = a;
`ifdef VIDEO_VRAM_MIRROR_EN
        if (a[13:12] == 2'b11 && a[11:8] != 4'hF) begin
            m[12] = 1'b0;
        end
`endif
        return m;
    endfunction

    // The requester only sees the ack one clock after the completing tick, so
    // the request still reads high during the ack clock; ignore it there to
    // avoid a duplicate fetch when ticks arrive back to back.
    assign render_req_eff = I_render_req & ~render_ack_q;
    assign host_req       = pend_valid_q;
    assign grant_render   = (state_q == ST_IDLE) & I_tick & render_req_eff
                          & (I_rendering | ~host_req);
    assign grant_host     = (state_q == ST_IDLE) & I_tick & host_req
                          & (~I_rendering | ~render_req_eff);
    assign complete       = (state_q == ST_ACCESS) & I_tick;

    // PPUADDR on the same clock wins; a busy slot also refuses the strobe.
    assign data_strobe    = I_data_wr | I_data_rd;
    assign host_accept    = data_strobe & ~I_addr_wr & ~pend_valid_q;
    assign incr           = I_incr32 ? L_incr_big : L_incr_one;

    always_ff @(posedge I_clock) begin : state_reg
        if (I_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_render || grant_host) state_d = ST_ACCESS;
            ST_ACCESS: if (I_tick) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin : output_logic
        v_d            = v_q;
        t_d            = t_q;
        w_d            = w_q;
        pend_valid_d   = pend_valid_q;
        pend_wr_d      = pend_wr_q;
        pend_addr_d    = pend_addr_q;
        pend_data_d    = pend_data_q;
        owner_render_d = owner_render_q;
        vid_addr_d     = vid_addr_q;
        vid_wren_d     = 1'b0;
        vid_data_d     = vid_data_q;
        render_ack_d   = 1'b0;
        render_data_d  = render_data_q;
        read_buffer_d  = read_buffer_q;
        overrun_d      = overrun_q;

        if (I_addr_wr) begin
            if (!w_q) begin
                t_d[P_addr_width-1:8] = (P_addr_width-8)'(I_host_data[5:0]);
                w_d = 1'b1;
            end else begin
                t_d[7:0] = I_host_data[7:0];
                v_d      = t_d;
                w_d      = 1'b0;
            end
        end

        // Status read is applied after a same-clock PPUADDR write.
        if (I_stat_rd) begin
            w_d = 1'b0;
        end

        if (data_strobe && !host_accept) begin
            overrun_d = 1'b1;
        end

        if (host_accept) begin
            pend_valid_d = 1'b1;
            pend_wr_d    = I_data_wr;
            pend_addr_d  = v_q;
            pend_data_d  = I_host_data;
            v_d          = v_q + incr;
        end

        if (grant_render) begin
            owner_render_d = 1'b1;
            vid_addr_d     = vid_map(I_render_addr);
        end else if (grant_host) begin
            owner_render_d = 1'b0;
            vid_addr_d     = vid_map(pend_addr_q);
            vid_data_d     = pend_data_q;
            vid_wren_d     = pend_wr_q;
        end

        if (complete) begin
            if (owner_render_q) begin
                render_ack_d  = 1'b1;
                render_data_d = I_vid_data;
            end else begin
                if (!pend_wr_q) begin
                    read_buffer_d = I_vid_data;
                end
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge I_clock) begin : datapath_reg
        if (I_reset) begin
            v_q            <= '0;
            t_q            <= '0;
            w_q            <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_wr_q      <= 1'b0;
            pend_addr_q    <= '0;
            pend_data_q    <= '0;
            owner_render_q <= 1'b0;
            vid_addr_q     <= '0;
            vid_wren_q     <= 1'b0;
            vid_data_q     <= '0;
            render_ack_q   <= 1'b0;
            render_data_q  <= '0;
            read_buffer_q  <= '0;
            overrun_q      <= 1'b0;
        end else begin
            v_q            <= v_d;
            t_q            <= t_d;
            w_q            <= w_d;
            pend_valid_q   <= pend_valid_d;
            pend_wr_q      <= pend_wr_d;
            pend_addr_q    <= pend_addr_d;
            pend_data_q    <= pend_data_d;
            owner_render_q <= owner_render_d;
            vid_addr_q     <= vid_addr_d;
            vid_wren_q     <= vid_wren_d;
            vid_data_q     <= vid_data_d;
            render_ack_q   <= render_ack_d;
            render_data_q  <= render_data_d;
            read_buffer_q  <= read_buffer_d;
            overrun_q      <= overrun_d;
        end
    end

    assign O_vid_addr    = vid_addr_q;
    assign O_vid_wren    = vid_wren_q;
    assign O_vid_data    = vid_data_q;
    assign O_render_ack  = render_ack_q;
    assign O_render_data = render_data_q;
    assign O_read_buffer = read_buffer_q;
    assign O_host_busy   = pend_valid_q;
    assign O_overrun     = overrun_q;

endmodule

// File: tb/tb_video_vram_arbiter.sv
// Self-checking bench for video_vram_arbiter: directed scenarios followed by a
// randomized host-operation sequence compared against a transaction-level model
// of the PPUADDR/PPUDATA rules and a shadow VRAM image.

module tb_video_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        rendering = 1'b0;
    logic        incr32 = 1'b0;
    logic        addr_wr = 1'b0;
    logic        data_wr = 1'b0;
    logic        data_rd = 1'b0;
    logic        stat_rd = 1'b0;
    logic [7:0]  host_data = 8'h00;
    logic [7:0]  read_buffer;
    logic        host_busy;
    logic        overrun;
    logic        render_req = 1'b0;
    logic [13:0] render_addr = 14'h0000;
    logic        render_ack;
    logic [7:0]  render_data;
    logic [13:0] vid_addr;
    logic        vid_wren;
    logic [7:0]  vid_rdata;
    logic [7:0]  vid_wdata;

    int total = 0;
    int bad   = 0;

    bit [7:0]    vram [0:16383];
    bit          vset [0:16383];
    logic        pre_en = 1'b0;
    logic [13:0] pre_addr = 14'h0;
    logic [7:0]  pre_data = 8'h0;
    logic [7:0]  mmem [0:16383];
    logic [13:0] wlog_addr [$];
    logic [7:0]  wlog_data [$];

    always #5 clk = ~clk;

    video_vram_arbiter dut (
        .I_clock       (clk),
        .I_reset       (rst),
        .I_tick        (tick),
        .I_rendering   (rendering),
        .I_incr32      (incr32),
        .I_addr_wr     (addr_wr),
        .I_data_wr     (data_wr),
        .I_data_rd     (data_rd),
        .I_stat_rd     (stat_rd),
        .I_host_data   (host_data),
        .O_read_buffer (read_buffer),
        .O_host_busy   (host_busy),
        .O_overrun     (overrun),
        .I_render_req  (render_req),
        .I_render_addr (render_addr),
        .O_render_ack  (render_ack),
        .O_render_data (render_data),
        .O_vid_addr    (vid_addr),
        .O_vid_wren    (vid_wren),
        .I_vid_data    (vid_rdata),
        .O_vid_data    (vid_wdata)
    );

    function automatic logic [7:0] init_val(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    function automatic logic [7:0] peek(input logic [13:0] a);
        return vset[a] ? vram[a] : init_val(a);
    endfunction

    function automatic logic [13:0] vmap(input logic [13:0] a);
`ifdef VIDEO_VRAM_MIRROR_EN
        if (a >= 14'h3000 && a <= 14'h3EFF) return a - 14'h1000;
`endif
        return a;
    endfunction

    assign vid_rdata = peek(vid_addr);

    always @(posedge clk) begin
        if (pre_en) begin
            vram[pre_addr] <= pre_data;
            vset[pre_addr] <= 1'b1;
        end
        if (vid_wren) begin
            vram[vid_addr] <= vid_wdata;
            vset[vid_addr] <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (vid_wren) begin
            wlog_addr.push_back(vid_addr);
            wlog_data.push_back(vid_wdata);
        end
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tk();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    task automatic do_addr(input logic [7:0] b);
        addr_wr = 1'b1; host_data = b;
        clk1();
        addr_wr = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] b);
        data_wr = 1'b1; host_data = b;
        clk1();
        data_wr = 1'b0;
    endtask

    task automatic do_rd();
        data_rd = 1'b1;
        clk1();
        data_rd = 1'b0;
    endtask

    task automatic do_stat();
        stat_rd = 1'b1;
        clk1();
        stat_rd = 1'b0;
    endtask

    task automatic poke(input logic [13:0] a, input logic [7:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        clk1();
        pre_en = 1'b0;
    endtask

    // Advance ticks until the host op finishes; bounded.
    task automatic run_host(input string tag, input bit rnd);
        for (int i = 0; i < 60 && host_busy; i++) begin
            tick = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            clk1();
            tick = 1'b0;
            if (!rnd) clk1();
        end
        total++;
        if (host_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout busy=%b exp=0", tag, host_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clk1();
        clk1();
        rst = 1'b0;
        total++;
        if ({vid_addr, vid_wren, vid_wdata} !== 23'h0) begin
            bad++;
            $display("FAIL reset_vid addr=%h wren=%b data=%h exp=0", vid_addr, vid_wren, vid_wdata);
        end
        total++;
        if ({read_buffer, host_busy, overrun, render_ack, render_data} !== 19'h0) begin
            bad++;
            $display("FAIL reset_host rb=%h busy=%b ovr=%b ack=%b rdata=%h exp=0",
                     read_buffer, host_busy, overrun, render_ack, render_data);
        end
    endtask

    task automatic test_reset_abort();
        poke(14'h0555, 8'hAB);
        do_addr(8'h05);
        do_addr(8'h55);
        do_rd();
        tk();
        total++;
        if (vid_addr !== 14'h0555) begin
            bad++;
            $display("FAIL abort_grant addr=%h exp=0555", vid_addr);
        end
        rst = 1'b1; tick = 1'b1;
        clk1();
        rst = 1'b0; tick = 1'b0;
        total++;
        if ({read_buffer, host_busy, vid_addr} !== 23'h0) begin
            bad++;
            $display("FAIL abort_state rb=%h busy=%b addr=%h exp=0", read_buffer, host_busy, vid_addr);
        end
        tk();
        clk1();
        total++;
        if ({render_ack, read_buffer} !== 9'h0) begin
            bad++;
            $display("FAIL abort_nocapture ack=%b rb=%h exp=0", render_ack, read_buffer);
        end
        do_rd();
        run_host("abort_rd", 1'b0);
        total++;
        if (vid_addr !== 14'h0000 || read_buffer !== peek(14'h0000)) begin
            bad++;
            $display("FAIL abort_v_reset addr=%h rb=%h exp=0000/%h", vid_addr, read_buffer, peek(14'h0000));
        end
    endtask

    task automatic test_write();
        int base;
        logic [7:0] rb_before;
        rb_before = read_buffer;
        do_addr(8'h21);
        do_addr(8'h08);
        base = wlog_addr.size();
        do_wr(8'h5A);
        total++;
        if (host_busy !== 1'b1) begin
            bad++;
            $display("FAIL wr_busy got=%b exp=1", host_busy);
        end
        tk();
        total++;
        if (vid_addr !== 14'h2108 || vid_wren !== 1'b1 || vid_wdata !== 8'h5A) begin
            bad++;
            $display("FAIL wr_grant addr=%h wren=%b data=%h exp=2108/1/5a", vid_addr, vid_wren, vid_wdata);
        end
        clk1();
        total++;
        if (vid_wren !== 1'b0 || host_busy !== 1'b1) begin
            bad++;
            $display("FAIL wr_pulse wren=%b busy=%b exp=0/1", vid_wren, host_busy);
        end
        tk();
        total++;
        if (host_busy !== 1'b0 || read_buffer !== rb_before) begin
            bad++;
            $display("FAIL wr_done busy=%b rb=%h exp=0/%h", host_busy, read_buffer, rb_before);
        end
        total++;
        if (wlog_addr.size() != base + 1 || peek(14'h2108) !== 8'h5A) begin
            bad++;
            $display("FAIL wr_count writes=%0d mem=%h exp=1/5a", wlog_addr.size() - base, peek(14'h2108));
        end
        do_rd();
        run_host("wr_next", 1'b0);
        total++;
        if (vid_addr !== 14'h2109) begin
            bad++;
            $display("FAIL wr_v_inc addr=%h exp=2109", vid_addr);
        end
    endtask

    task automatic test_incr32();
        int base;
        incr32 = 1'b1;
        do_addr(8'h20);
        do_addr(8'h00);
        base = wlog_addr.size();
        do_wr(8'hA1);
        run_host("inc_w1", 1'b0);
        do_wr(8'hB2);
        run_host("inc_w2", 1'b0);
        total++;
        if (wlog_addr.size() != base + 2) begin
            bad++;
            $display("FAIL inc_count got=%0d exp=2", wlog_addr.size() - base);
        end else begin
            total++;
            if (wlog_addr[base] !== 14'h2000 || wlog_addr[base+1] !== 14'h2020) begin
                bad++;
                $display("FAIL inc_addrs got=%h,%h exp=2000,2020", wlog_addr[base], wlog_addr[base+1]);
            end
        end
        do_rd();
        run_host("inc_rd", 1'b0);
        total++;
        if (vid_addr !== 14'h2040) begin
            bad++;
            $display("FAIL inc_v addr=%h exp=2040", vid_addr);
        end
        incr32 = 1'b0;
    endtask

    task automatic test_read_lag();
        poke(14'h2000, 8'h11);
        poke(14'h2001, 8'h22);
        do_addr(8'h20);
        do_addr(8'h00);
        do_rd();
        run_host("lag_r1", 1'b0);
        total++;
        if (read_buffer !== 8'h11) begin
            bad++;
            $display("FAIL lag_first rb=%h exp=11", read_buffer);
        end
        do_rd();
        run_host("lag_r2", 1'b0);
        total++;
        if (read_buffer !== 8'h22) begin
            bad++;
            $display("FAIL lag_second rb=%h exp=22", read_buffer);
        end
    endtask

    task automatic test_priority();
        poke(14'h0123, 8'hC3);
        rendering = 1'b1;
        do_addr(8'h22);
        do_addr(8'h00);
        do_wr(8'h99);
        render_addr = 14'h0123;
        render_req  = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tk();
            total++;
            if (vid_addr !== 14'h0123 || vid_wren !== 1'b0 || host_busy !== 1'b1) begin
                bad++;
                $display("FAIL prio_render_grant%0d addr=%h wren=%b busy=%b exp=0123/0/1",
                         r, vid_addr, vid_wren, host_busy);
            end
            clk1();
            tk();
            total++;
            if (render_ack !== 1'b1 || render_data !== 8'hC3) begin
                bad++;
                $display("FAIL prio_render_ack%0d ack=%b data=%h exp=1/c3", r, render_ack, render_data);
            end
            clk1();
        end
        render_req = 1'b0;
        tk();
        total++;
        if (vid_addr !== 14'h2200 || vid_wren !== 1'b1 || vid_wdata !== 8'h99) begin
            bad++;
            $display("FAIL prio_host_grant addr=%h wren=%b data=%h exp=2200/1/99", vid_addr, vid_wren, vid_wdata);
        end
        clk1();
        tk();
        clk1();
        rendering = 1'b0;
        do_rd();
        render_req = 1'b1;
        tk();
        total++;
        if (vid_addr !== 14'h2201) begin
            bad++;
            $display("FAIL prio_host_first addr=%h exp=2201", vid_addr);
        end
        clk1();
        tk();
        total++;
        if (read_buffer !== peek(14'h2201) || render_ack !== 1'b0) begin
            bad++;
            $display("FAIL prio_host_done rb=%h ack=%b exp=%h/0", read_buffer, render_ack, peek(14'h2201));
        end
        clk1();
        tk();
        total++;
        if (vid_addr !== 14'h0123) begin
            bad++;
            $display("FAIL prio_render_after addr=%h exp=0123", vid_addr);
        end
        clk1();
        tk();
        render_req = 1'b0;
        total++;
        if (render_ack !== 1'b1 || render_data !== 8'hC3) begin
            bad++;
            $display("FAIL prio_render_late ack=%b data=%h exp=1/c3", render_ack, render_data);
        end
        clk1();
    endtask

    task automatic test_stat_rd();
        do_addr(8'h12);
        do_stat();
        do_addr(8'h3F);
        do_addr(8'h00);
        do_rd();
        run_host("stat_rd", 1'b0);
        total++;
        if (vid_addr !== 14'h3F00) begin
            bad++;
            $display("FAIL stat_clear addr=%h exp=3f00", vid_addr);
        end
        addr_wr = 1'b1; stat_rd = 1'b1; host_data = 8'h2A;
        clk1();
        addr_wr = 1'b0; stat_rd = 1'b0;
        do_addr(8'h15);
        do_addr(8'h40);
        do_rd();
        run_host("stat_same", 1'b0);
        total++;
        if (vid_addr !== 14'h1540) begin
            bad++;
            $display("FAIL stat_same_clk addr=%h exp=1540", vid_addr);
        end
    endtask

    task automatic test_mirror();
        do_addr(8'h31);
        do_addr(8'h23);
        do_rd();
        run_host("mir_rd", 1'b0);
        total++;
        if (vid_addr !== vmap(14'h3123) || read_buffer !== peek(vmap(14'h3123))) begin
            bad++;
            $display("FAIL mirror_host addr=%h rb=%h exp=%h/%h", vid_addr, read_buffer,
                     vmap(14'h3123), peek(vmap(14'h3123)));
        end
        render_addr = 14'h3456;
        render_req  = 1'b1;
        tk();
        render_req  = 1'b0;
        total++;
        if (vid_addr !== vmap(14'h3456)) begin
            bad++;
            $display("FAIL mirror_render addr=%h exp=%h", vid_addr, vmap(14'h3456));
        end
        clk1();
        tk();
        clk1();
    endtask

    task automatic test_wrap_overrun();
        int base;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_pre got=%b exp=0", overrun);
        end
        do_addr(8'h3F);
        do_addr(8'hFF);
        base = wlog_addr.size();
        do_wr(8'h77);
        do_wr(8'h88);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set got=%b exp=1", overrun);
        end
        run_host("ovr_w", 1'b0);
        total++;
        if (wlog_addr.size() != base + 1 || peek(14'h3FFF) !== 8'h77) begin
            bad++;
            $display("FAIL ovr_dropped writes=%0d mem=%h exp=1/77", wlog_addr.size() - base, peek(14'h3FFF));
        end
        do_rd();
        run_host("ovr_rd", 1'b0);
        total++;
        if (vid_addr !== 14'h0000 || overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_wrap addr=%h ovr=%b exp=0000/1", vid_addr, overrun);
        end
    endtask

    task automatic test_random();
        logic [13:0] mv, mt, a;
        bit          mw, movr;
        logic [7:0]  mrb, b;
        int          kind, inc;
        rst = 1'b1;
        clk1();
        rst = 1'b0;
        mv = 14'h0; mt = 14'h0; mw = 1'b0; movr = 1'b0; mrb = 8'h00;
        for (int i = 0; i < 16384; i++) mmem[i] = peek(14'(i));
        for (int k = 0; k < 80; k++) begin
            kind      = $urandom_range(0, 9);
            b         = 8'($urandom);
            rendering = 1'($urandom_range(0, 1));
            inc       = incr32 ? 32 : 1;
            case (kind)
                0, 1, 2: begin
                    do_addr(b);
                    if (!mw) mt = (mt & 14'h00FF) | (14'(b & 8'h3F) << 8);
                    else begin mt = (mt & 14'h3F00) | 14'(b); mv = mt; end
                    mw = !mw;
                end
                3: begin
                    do_stat();
                    mw = 1'b0;
                end
                4, 5: begin
                    a  = mv;
                    mv = 14'((int'(mv) + inc) % 16384);
                    do_wr(b);
                    run_host("rnd_wr", 1'b1);
                    mmem[vmap(a)] = b;
                    total++;
                    if (vid_addr !== vmap(a) || peek(vmap(a)) !== b) begin
                        bad++;
                        $display("FAIL rnd_write addr=%h mem=%h exp=%h/%h", vid_addr, peek(vmap(a)), vmap(a), b);
                    end
                end
                6, 7: begin
                    a  = mv;
                    mv = 14'((int'(mv) + inc) % 16384);
                    do_rd();
                    run_host("rnd_rd", 1'b1);
                    mrb = mmem[vmap(a)];
                    total++;
                    if (vid_addr !== vmap(a)) begin
                        bad++;
                        $display("FAIL rnd_read_addr addr=%h exp=%h", vid_addr, vmap(a));
                    end
                end
                8: begin
                    addr_wr = 1'b1; host_data = b;
                    if (b[0]) data_wr = 1'b1; else data_rd = 1'b1;
                    clk1();
                    addr_wr = 1'b0; data_wr = 1'b0; data_rd = 1'b0;
                    if (!mw) mt = (mt & 14'h00FF) | (14'(b & 8'h3F) << 8);
                    else begin mt = (mt & 14'h3F00) | 14'(b); mv = mt; end
                    mw   = !mw;
                    movr = 1'b1;
                    total++;
                    if (host_busy !== 1'b0) begin
                        bad++;
                        $display("FAIL rnd_combo_busy got=%b exp=0", host_busy);
                    end
                end
                default: begin
                    incr32 = 1'($urandom_range(0, 1));
                end
            endcase
            total++;
            if (read_buffer !== mrb || overrun !== movr) begin
                bad++;
                $display("FAIL rnd_state op=%0d rb=%h ovr=%b exp=%h/%b", k, read_buffer, overrun, mrb, movr);
            end
        end
        incr32 = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_abort();
        test_write();
        test_incr32();
        test_read_lag();
        test_priority();
        test_stat_rd();
        test_mirror();
        test_wrap_overrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
